anemo_freq_measure: RTL and testbench

ANEMO_FREQ_MEASURE -- requirements
Module: anemo_freq_measure

---
 rtl/anemo_pkg.sv | 12 +
 rtl/anemo_pulse_cond.sv | 46 ++++
 rtl/anemo_freq_measure.sv | 87 ++++++++
 tb/tb_anemo_freq_measure.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/anemo_pkg.sv
// Shared types and constants for the anemometer frequency meter.
package anemo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DONE
    } state_t;

    localparam int ANEMO_GATE_CYCLES_DEFAULT = 50000000;

endpackage

// File: rtl/anemo_pulse_cond.sv
// Pulse conditioning: 2-flop synchronizer, optional 3-sample majority filter
// (enabled by macro ANEMO_GLITCH_FILTER_EN) and rising-edge detector.
module anemo_pulse_cond (
    input  logic clk,
    input  logic reset,
    input  logic in_freq,
    output logic pulse_sync,
    output logic rise
);

    logic [1:0] sync;
    logic       prev;

    always_ff @(posedge clk) begin
        if (reset) sync <= '0;
        else       sync <= {sync[0], in_freq};
    end

`ifdef ANEMO_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic       filt;

    // Majority of the three most recent samples, registered: two extra cycles of latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist <= '0;
            filt <= 1'b0;
        end else begin
            hist <= {hist[0], sync[1]};
            filt <= (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);
        end
    end

    assign pulse_sync = filt;
`else
    assign pulse_sync = sync[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b0;
        else       prev <= pulse_sync;
    end

    assign rise = pulse_sync & ~prev;

endmodule

// File: rtl/anemo_freq_measure.sv
// Anemometer frequency meter: counts rising edges of in_freq over a gate window
// of GATE_CYCLES clocks, in continuous or single-shot mode. Optional glitch
// filter enabled by macro ANEMO_GLITCH_FILTER_EN.
module anemo_freq_measure
    import anemo_pkg::*;
#(
    parameter int GATE_CYCLES = ANEMO_GATE_CYCLES_DEFAULT,
    parameter int FREQ_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_freq,
    input  logic              continu,
    input  logic              start_stop,
    output logic [FREQ_W-1:0] freq,
    output logic              data_valid,
    output logic              pulse_sync
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]     GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [FREQ_W-1:0] CNT_MAX   = '1;

    state_t            state, state_nxt;
    logic [GW-1:0]     gate_cnt;
    logic [FREQ_W-1:0] edge_cnt, edge_nxt;
    logic              rise, win_end, run, valid_clr;

    anemo_pulse_cond u_cond (
        .clk        (clk),
        .reset      (reset),
        .in_freq    (in_freq),
        .pulse_sync (pulse_sync),
        .rise       (rise)
    );

    // Saturating edge count including this cycle's edge, so the last gate cycle is not lost.
    assign edge_nxt = (rise && edge_cnt != CNT_MAX) ? edge_cnt + 1'b1 : edge_cnt;
    assign win_end  = (state == MEASURE) && (gate_cnt == GATE_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (continu || start_stop) state_nxt = MEASURE;
            MEASURE: if (win_end) state_nxt = continu ? MEASURE : DONE;
            DONE: begin
                if (continu)          state_nxt = MEASURE;
                else if (!start_stop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        run       = (state == MEASURE);
        valid_clr = (state == DONE) && !continu && !start_stop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            freq       <= '0;
            data_valid <= 1'b0;
        end else begin
            if (run && !win_end) begin
                gate_cnt <= gate_cnt + 1'b1;
                edge_cnt <= edge_nxt;
            end else begin
                gate_cnt <= '0;
                edge_cnt <= '0;
            end
            if (win_end) begin
                freq       <= edge_nxt;
                data_valid <= 1'b1;
            end else if (valid_clr) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_anemo_freq_measure.sv
// Directed bench for anemo_freq_measure (GATE_CYCLES=100); a second FREQ_W=5
// instance shares the stimulus for the saturation case.
module tb_anemo_freq_measure;

`ifdef ANEMO_GLITCH_FILTER_EN
    localparam int LAT  = 4;
    localparam int FILT = 1;
`else
    localparam int LAT  = 2;
    localparam int FILT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, in_freq, continu, start_stop;
    logic [7:0] freq;
    logic       dv, ps;
    logic [4:0] freq5;
    logic       dv5, ps5;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    anemo_freq_measure #(.GATE_CYCLES(100), .FREQ_W(8)) dut (
        .clk(clk), .reset(reset), .in_freq(in_freq), .continu(continu),
        .start_stop(start_stop), .freq(freq), .data_valid(dv), .pulse_sync(ps)
    );

    anemo_freq_measure #(.GATE_CYCLES(100), .FREQ_W(5)) dut5 (
        .clk(clk), .reset(reset), .in_freq(in_freq), .continu(continu),
        .start_stop(start_stop), .freq(freq5), .data_valid(dv5), .pulse_sync(ps5)
    );

    // Input pattern per scenario, indexed by cycles since the window opened.
    function automatic logic pat(input int mode, input int i);
        case (mode)
            0: return (i % 10) < 5;
            1: return (i < 70) && ((i % 10) < 5);
            2: return (i % 2) == 0;
            3: return (i >= 99 - LAT && i < 102 - LAT) || (i >= 200 - LAT && i < 203 - LAT);
            4: return (i < 50) ? (i % 10 == 0) : (i % 10 < 3);
            5: return (i < 30) && ((i % 10) < 5);
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int mode, input int i);
        in_freq = pat(mode, i);
        step();
    endtask

    // Leaves the bench just after the edge at which MEASURE is entered (gate count 0).
    task automatic start_run(input logic c, input logic s);
        reset = 1'b1; in_freq = 1'b0; continu = c; start_stop = s;
        repeat (3) step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_freq = 1'b1; continu = 1'b1; start_stop = 1'b1;
        repeat (4) step();
        checks++;
        if (freq !== 8'd0 || dv !== 1'b0 || ps !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got freq=%0d dv=%0b ps=%0b want 0 0 0", freq, dv, ps);
        end
    endtask

    task automatic test_continuous();
        start_run(1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            tick(0, i);
            if (i == 98) begin
                checks++;
                if (dv !== 1'b0 || freq !== 8'd0) begin
                    errors++;
                    $display("FAIL cont_before_first got dv=%0b freq=%0d want 0 0", dv, freq);
                end
            end
            if ((i + 1) % 100 == 0) begin
                checks++;
                if (freq !== 8'd10 || dv !== 1'b1) begin
                    errors++;
                    $display("FAIL cont_window%0d got freq=%0d dv=%0b want 10 1", (i + 1) / 100, freq, dv);
                end
            end
        end
    endtask

    task automatic test_single_shot();
        start_run(1'b0, 1'b1);
        for (int i = 0; i < 100; i++) tick(1, i);
        checks++;
        if (freq !== 8'd7 || dv !== 1'b1) begin
            errors++;
            $display("FAIL ss_result got freq=%0d dv=%0b want 7 1", freq, dv);
        end
        for (int i = 100; i < 105; i++) tick(1, i);
        checks++;
        if (freq !== 8'd7 || dv !== 1'b1) begin
            errors++;
            $display("FAIL ss_hold got freq=%0d dv=%0b want 7 1", freq, dv);
        end
        start_stop = 1'b0;
        tick(1, 105);
        checks++;
        if (freq !== 8'd7 || dv !== 1'b0) begin
            errors++;
            $display("FAIL ss_release got freq=%0d dv=%0b want 7 0", freq, dv);
        end
        for (int i = 106; i < 130; i++) tick(0, i);
        checks++;
        if (freq !== 8'd7 || dv !== 1'b0) begin
            errors++;
            $display("FAIL ss_idle got freq=%0d dv=%0b want 7 0", freq, dv);
        end
    endtask

    task automatic test_abort_ss();
        start_run(1'b0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (i == 50) start_stop = 1'b0;
            tick(1, i);
        end
        checks++;
        if (freq !== 8'd7 || dv !== 1'b1) begin
            errors++;
            $display("FAIL ss_abort_publish got freq=%0d dv=%0b want 7 1", freq, dv);
        end
        tick(1, 100);
        checks++;
        if (freq !== 8'd7 || dv !== 1'b0) begin
            errors++;
            $display("FAIL ss_abort_exit got freq=%0d dv=%0b want 7 0", freq, dv);
        end
    endtask

    task automatic test_saturation();
        start_run(1'b1, 1'b0);
        for (int i = 0; i < 200; i++) begin
            tick(2, i);
            if (i == 99) begin
                checks++;
                if (freq5 !== 5'd31 || dv5 !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_w1 got freq5=%0d dv5=%0b want 31 1", freq5, dv5);
                end
            end
        end
        checks++;
        if (freq5 !== 5'd31 || freq !== 8'd50) begin
            errors++;
            $display("FAIL sat_w2 got freq5=%0d freq=%0d want 31 50", freq5, freq);
        end
    endtask

    task automatic test_boundary();
        int exp [3] = '{1, 0, 1};
        start_run(1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            tick(3, i);
            if ((i + 1) % 100 == 0) begin
                checks++;
                if (freq !== 8'(exp[i / 100])) begin
                    errors++;
                    $display("FAIL boundary_w%0d got freq=%0d want %0d", i / 100 + 1, freq, exp[i / 100]);
                end
            end
        end
    endtask

    task automatic test_reset_midwindow();
        start_run(1'b1, 1'b0);
        for (int i = 0; i < 150; i++) tick(0, i);
        checks++;
        if (freq !== 8'd10 || dv !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got freq=%0d dv=%0b want 10 1", freq, dv);
        end
        reset = 1'b1; in_freq = 1'b0;
        step();
        checks++;
        if (freq !== 8'd0 || dv !== 1'b0 || ps !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got freq=%0d dv=%0b ps=%0b want 0 0 0", freq, dv, ps);
        end
        reset = 1'b0;
        step();
        for (int i = 0; i < 100; i++) begin
            tick(5, i);
            if (i == 98) begin
                checks++;
                if (dv !== 1'b0) begin
                    errors++;
                    $display("FAIL midrst_dv got dv=%0b want 0", dv);
                end
            end
        end
        checks++;
        if (freq !== 8'd3 || dv !== 1'b1) begin
            errors++;
            $display("FAIL midrst_next got freq=%0d dv=%0b want 3 1", freq, dv);
        end
    endtask

    task automatic test_glitch();
        start_run(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            tick(4, i);
            if (i == 48 + LAT) begin
                checks++;
                if (ps !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch_lat_early got ps=%0b want 0", ps);
                end
            end
            if (i == 49 + LAT) begin
                checks++;
                if (ps !== 1'b1) begin
                    errors++;
                    $display("FAIL glitch_lat got ps=%0b want 1", ps);
                end
            end
        end
        checks++;
        if (freq !== (FILT ? 8'd5 : 8'd10)) begin
            errors++;
            $display("FAIL glitch_count got freq=%0d want %0d", freq, FILT ? 5 : 10);
        end
    endtask

    initial begin
        reset = 1'b1; in_freq = 1'b0; continu = 1'b0; start_stop = 1'b0;
        test_reset();
        test_continuous();
        test_single_shot();
        test_abort_ss();
        test_saturation();
        test_boundary();
        test_reset_midwindow();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
